alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 32 +++
 rtl/alu_ctrl_decode.sv | 69 ++++++
 rtl/alu_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared decode constants, FSM state type and ALU select bundle for alu_ctrl.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic sel_add;
    logic sel_sub;
    logic sel_and;
    logic sel_or;
    logic sel_slt;
  } alu_sel_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I subset decoder: instruction word to one-hot ALU select,
// immediate-use, branch type and illegal flag. Illegal encodings yield no select.
module alu_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output alu_sel_t    o_sel,
  output logic        o_use_imm,
  output logic        o_is_branch,
  output logic        o_br_ne,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_unused_fields;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_unused_fields = ^{i_instr[19:15], i_instr[11:7]};

  always_comb begin
    o_sel       = '0;
    o_use_imm   = 1'b0;
    o_is_branch = 1'b0;
    o_br_ne     = 1'b0;
    o_illegal   = 1'b1;
    case (w_opc)
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          o_illegal = 1'b0;
          case (w_f3)
            F3_ADD:  o_sel.sel_add = 1'b1;
            F3_AND:  o_sel.sel_and = 1'b1;
            F3_OR:   o_sel.sel_or  = 1'b1;
            F3_SLT:  o_sel.sel_slt = 1'b1;
            default: o_illegal     = 1'b1;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
          o_illegal     = 1'b0;
          o_sel.sel_sub = 1'b1;
        end
      end
      OPC_OPIMM: begin
        o_use_imm = 1'b1;
        o_illegal = 1'b0;
        case (w_f3)
          F3_ADD:  o_sel.sel_add = 1'b1;
          F3_AND:  o_sel.sel_and = 1'b1;
          F3_OR:   o_sel.sel_or  = 1'b1;
          F3_SLT:  o_sel.sel_slt = 1'b1;
          default: o_illegal     = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        if (w_f3 == F3_BEQ || w_f3 == F3_BNE) begin
          o_illegal     = 1'b0;
          o_is_branch   = 1'b1;
          o_br_ne       = (w_f3 == F3_BNE);
          o_sel.sel_sub = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Three-cycle ALU sequencer: captures an instruction in IDLE, drives the external
// ALU in EXEC, and presents a held completion record in DONE until accepted.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_and,
  output logic             alu_sel_or,
  output logic             alu_sel_slt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_we,
  output logic             branch_taken,
  output logic             illegal
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;
  logic [4:0]       r_rd_addr;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_we;
  logic             r_branch_taken;
  logic             r_illegal;

  alu_sel_t         w_dec_sel;
  alu_sel_t         w_sel;
  logic             w_dec_use_imm;
  logic             w_dec_is_branch;
  logic             w_dec_br_ne;
  logic             w_dec_illegal;
  logic             w_hs;
  logic [WIDTH-1:0] w_imm;

  alu_decode u_decode (
    .i_instr     (r_instr),
    .o_sel       (w_dec_sel),
    .o_use_imm   (w_dec_use_imm),
    .o_is_branch (w_dec_is_branch),
    .o_br_ne     (w_dec_br_ne),
    .o_illegal   (w_dec_illegal)
  );

  assign w_hs  = in_valid && in_ready;
  assign w_imm = {{(WIDTH-12){r_instr[31]}}, r_instr[31:20]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_sel     = '0;
    operand_a = '0;
    operand_b = '0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: begin
        w_sel     = w_dec_sel;
        operand_a = r_rs1;
        operand_b = w_dec_use_imm ? w_imm : r_rs2;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign alu_sel_add = w_sel.sel_add;
  assign alu_sel_sub = w_sel.sel_sub;
  assign alu_sel_and = w_sel.sel_and;
  assign alu_sel_or  = w_sel.sel_or;
  assign alu_sel_slt = w_sel.sel_slt;

  // Record fields only load at the end of EXEC, so they stay frozen through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr        <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd_addr      <= '0;
      r_rd_data      <= '0;
      r_rd_we        <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_instr <= instr;
        r_rs1   <= rs1_data;
        r_rs2   <= rs2_data;
      end
      if (r_state == ST_EXEC) begin
        r_rd_addr      <= r_instr[11:7];
        r_rd_data      <= w_dec_illegal ? '0 : alu_result;
        r_rd_we        <= !w_dec_illegal && !w_dec_is_branch && (r_instr[11:7] != 5'd0);
        r_branch_taken <= !w_dec_illegal && w_dec_is_branch && (w_dec_br_ne ? !alu_zero : alu_zero);
        r_illegal      <= w_dec_illegal;
      end
    end
  end

  assign rd_addr      = r_rd_addr;
  assign rd_data      = r_rd_data;
  assign rd_we        = r_rd_we;
  assign branch_taken = r_branch_taken;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU and instruction-level reference model,
// directed literal pins plus randomized traffic with resets and back-pressure.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] operand_a, operand_b;
  logic        alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we, branch_taken, illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .operand_a(operand_a), .operand_b(operand_b),
    .alu_sel_add(alu_sel_add), .alu_sel_sub(alu_sel_sub), .alu_sel_and(alu_sel_and),
    .alu_sel_or(alu_sel_or), .alu_sel_slt(alu_sel_slt), .alu_result(alu_result),
    .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_we(rd_we), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU in the environment
  always_comb begin
    alu_result = '0;
    if (alu_sel_add)      alu_result = operand_a + operand_b;
    else if (alu_sel_sub) alu_result = operand_a - operand_b;
    else if (alu_sel_and) alu_result = operand_a & operand_b;
    else if (alu_sel_or)  alu_result = operand_a | operand_b;
    else if (alu_sel_slt) alu_result = ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct packed {
    logic [4:0]  sel;
    logic        ill;
    logic [31:0] opb;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        taken;
  } exp_t;

  // Instruction-level reference: op chosen from a lookup, result by plain arithmetic.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b2);
    exp_t        e;
    int          op = 0;
    logic        br = 1'b0;
    logic        ne = 1'b0;
    logic [31:0] b, res;
    logic [9:0]  key = {ins[31:25], ins[14:12]};
    if (ins[6:0] == 7'h33) begin
      if (key == 10'h000) op = 1;
      else if (key == 10'h100) op = 2;
      else if (key == 10'h007) op = 3;
      else if (key == 10'h006) op = 4;
      else if (key == 10'h002) op = 5;
    end else if (ins[6:0] == 7'h13) begin
      if (ins[14:12] == 3'd0) op = 1;
      else if (ins[14:12] == 3'd7) op = 3;
      else if (ins[14:12] == 3'd6) op = 4;
      else if (ins[14:12] == 3'd2) op = 5;
    end else if (ins[6:0] == 7'h63 && ins[14:13] == 2'b00) begin
      op = 2; br = 1'b1; ne = ins[12];
    end
    b = (ins[6:0] == 7'h13) ? 32'(signed'(ins[31:20])) : b2;
    case (op)
      1: res = a + b;
      2: res = a - b;
      3: res = a & b;
      4: res = a | b;
      5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    e.ill   = (op == 0);
    e.sel   = e.ill ? 5'b0 : 5'(5'b10000 >> (op - 1));
    e.opb   = b;
    e.addr  = ins[11:7];
    e.data  = e.ill ? 32'd0 : res;
    e.we    = !e.ill && !br && (ins[11:7] != 5'd0);
    e.taken = !e.ill && br && (ne ? (res != 0) : (res == 0));
    return e;
  endfunction

  // Reference timeline: 0 = idle, 1 = exec, 2 = done
  int          m_phase = 0;
  logic        m_live = 1'b0;
  logic        m_rec_zero = 1'b1;
  exp_t        m_exp = '0;
  logic [31:0] m_a = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_rec_zero = 1'b1; m_live = 1'b1;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_exp = ref_model(instr, rs1_data, rs2_data);
        m_a = rs1_data;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_rec_zero = 1'b0;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  // Hand-computed literal pins for directed instructions
  logic        pin_en = 1'b0, pin_opb_en = 1'b0;
  logic [4:0]  pin_sel = '0, pin_addr = '0;
  logic [31:0] pin_opb = '0, pin_data = '0;
  logic        pin_we = 1'b0, pin_taken = 1'b0, pin_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [4:0] w_sel_vec;
  assign w_sel_vec = {alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt};

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("selects", 32'(w_sel_vec), (m_phase == 1) ? 32'(m_exp.sel) : 32'd0);
      chk("operand_a", operand_a, (m_phase == 1) ? m_a : 32'd0);
      if (m_phase != 1) chk("operand_b_idle", operand_b, 32'd0);
      else if (!m_exp.ill) chk("operand_b", operand_b, m_exp.opb);
      if (m_phase == 2) begin
        chk("rd_addr", 32'(rd_addr), 32'(m_exp.addr));
        chk("rd_data", rd_data, m_exp.data);
        chk("rd_we", 32'(rd_we), 32'(m_exp.we));
        chk("branch_taken", 32'(branch_taken), 32'(m_exp.taken));
        chk("illegal", 32'(illegal), 32'(m_exp.ill));
      end else if (m_rec_zero) begin
        chk("reset_record", {rd_data[26:0] | 27'(rd_data[31:27]), rd_addr}, 32'd0);
        chk("reset_flags", 32'({rd_we, branch_taken, illegal}), 32'd0);
      end
      if (pin_en && m_phase == 1) begin
        chk("pin_sel", 32'(w_sel_vec), 32'(pin_sel));
        if (pin_opb_en) chk("pin_opb", operand_b, pin_opb);
      end
      if (pin_en && m_phase == 2) begin
        chk("pin_addr", 32'(rd_addr), 32'(pin_addr));
        chk("pin_data", rd_data, pin_data);
        chk("pin_flags", 32'({rd_we, branch_taken, illegal}), 32'({pin_we, pin_taken, pin_ill}));
        chk("pin_model_data", m_exp.data, pin_data);
      end
    end
  end

  task automatic set_pins(input logic [4:0] sel, input logic opb_en, input logic [31:0] opb,
                          input logic [4:0] addr, input logic [31:0] data,
                          input logic we, input logic taken, input logic ill);
    pin_en = 1'b1; pin_sel = sel; pin_opb_en = opb_en; pin_opb = opb; pin_addr = addr;
    pin_data = data; pin_we = we; pin_taken = taken; pin_ill = ill;
  endtask

  // Issue from IDLE; garbage on in_valid during EXEC/DONE must be ignored.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned hold);
    in_valid = 1'b1; instr = ins; rs1_data = a; rs2_data = b; out_ready = 1'b0;
    @(posedge clk); #2;
    instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    @(posedge clk); #2;
    repeat (hold) begin @(posedge clk); #2; end
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b0; pin_en = 1'b0;
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    logic [9:0]  rkeys [5] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h002};
    logic [9:0]  k;
    case ($urandom_range(0, 5))
      0: begin
        k = rkeys[$urandom_range(0, 4)];
        w = {k[9:3], w[24:15], k[2:0], w[11:7], 7'h33};
      end
      1: w = {w[31:7], 7'h13};
      2: w = {w[31:15], 2'b00, w[12], w[11:7], 7'h63};
      3: w = {w[31:7], 7'h63};
      4: w = {w[31:7], 7'h33};
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    set_pins(5'b10000, 1'b1, 32'd7, 5'd3, 32'd12, 1'b1, 1'b0, 1'b0);
    issue(32'h002081B3, 32'd5, 32'd7, 4);
    set_pins(5'b01000, 1'b1, 32'd9, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(32'h00208063, 32'd9, 32'd9, 0);
    set_pins(5'b01000, 1'b1, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    issue(32'h00209063, 32'd9, 32'd9, 1);
    set_pins(5'b10000, 1'b1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    issue(32'hFFF08013, 32'd1, 32'd55, 0);
    set_pins(5'b00000, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    issue(32'h0000007F, 32'd3, 32'd4, 2);

    // Reset while in EXEC: in-flight instruction is dropped
    in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; out_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      instr     = gen_instr();
      rs1_data  = $urandom;
      rs2_data  = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #2;
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
